stream_sorter: RTL

Sequential, handshaked sorter. Accepts N words one per beat on a valid/ready input stream, sorts them in place with odd-even transposition passes, and drains the sorted frame on a valid/ready output stream. It is the serial-stream counterpart of the team's combinational array sorter. It sits between a producer that cannot present a whole array at once and a consumer expecting ordered beats with a frame-end marker.

---
 rtl/sort_pkg.sv | 15 +
 rtl/sort_cmp_swap.sv | 24 ++
 rtl/stream_sorter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types for the stream sorter: frame state encoding and counter-width helper.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-swap cell; order set by SORT_DESCENDING_EN (ascending when undefined).
module sort_cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic swap;

`ifdef SORT_DESCENDING_EN
    assign swap = en && (a < b);
`else
    assign swap = en && (a > b);
`endif

    // Ties never swap, so equal words keep their arrival order.
    assign lo = swap ? b : a;
    assign hi = swap ? a : b;

endmodule

// File: rtl/stream_sorter.sv
// Serial odd-even transposition sorter: load N words, run N phases, drain in order.
// Optional SORT_DESCENDING_EN reverses the output order.
module stream_sorter
    import sort_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int IW = cnt_w(N);
    localparam int PW = cnt_w(N + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(N - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    phase;
    logic [WIDTH-1:0] mem      [N];
    logic [WIDTH-1:0] even_nxt [N];
    logic [WIDTH-1:0] odd_nxt  [N];

    // Even cells pair (0,1),(2,3)...; odd cells pair (1,2),(3,4)...; parity picks the bank.
    for (genvar k = 0; k < N - 1; k++) begin : g_cell
        if (k % 2 == 0) begin : g_even
            sort_cmp_swap #(.WIDTH(WIDTH)) u_cs (
                .a  (mem[k]),
                .b  (mem[k+1]),
                .en (~phase[0]),
                .lo (even_nxt[k]),
                .hi (even_nxt[k+1])
            );
        end else begin : g_odd
            sort_cmp_swap #(.WIDTH(WIDTH)) u_cs (
                .a  (mem[k]),
                .b  (mem[k+1]),
                .en (phase[0]),
                .lo (odd_nxt[k]),
                .hi (odd_nxt[k+1])
            );
        end
    end

    assign odd_nxt[0] = mem[0];
    if (N % 2 == 1) begin : g_pass_odd_n
        assign even_nxt[N-1] = mem[N-1];
    end else begin : g_pass_even_n
        assign odd_nxt[N-1] = mem[N-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            idx   <= '0;
            phase <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            phase <= '0;
                            state <= SORT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (phase == PH_LAST) begin
                        idx   <= '0;
                        phase <= '0;
                        state <= DRAIN;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= LOAD;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    idx   <= '0;
                    phase <= '0;
                    state <= LOAD;
                end
            endcase
        end
    end

    // Word storage is never reset; contents only matter once a full frame has loaded.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem[idx] <= in_data;
        end else if (state == SORT) begin
            for (int k = 0; k < N; k++) begin
                mem[k] <= phase[0] ? odd_nxt[k] : even_nxt[k];
            end
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (idx == IDX_LAST);
    assign busy      = (state != LOAD);
    assign out_data  = mem[idx];

endmodule
